// File: rtl/ysyx_25030077_imem_rsp_if.sv
// Fetch read channel between the fetch unit (master) and the instruction memory responder (slave).
// AR carries one byte address; R returns one instruction word with its status.
interface ysyx_25030077_imem_rsp_if;
    logic        ar_ready;
    logic        ar_valid;
    logic [31:0] ar_bits_addr;
    logic        r_ready;
    logic        r_valid;
    logic [31:0] r_bits_data;
    logic [1:0]  r_bits_resp;

    modport master (
        input  ar_ready, r_valid, r_bits_data, r_bits_resp,
        output ar_valid, ar_bits_addr, r_ready
    );

    modport slave (
        output ar_ready, r_valid, r_bits_data, r_bits_resp,
        input  ar_valid, ar_bits_addr, r_ready
    );
endinterface

// File: rtl/ysyx_25030077_imem_rsp.sv
// Instruction memory read responder: one outstanding fetch, programmable wait, registered response.
// A side load port preloads program images into the word array in any state.
module ysyx_25030077_imem_rsp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    ysyx_25030077_imem_rsp_if.slave        io,
    input  logic                           io_ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] io_ld_idx,
    input  logic [31:0]                    io_ld_data
);
    localparam int          IW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [IW-1:0] idx_q;
    logic          err_q;
    logic [31:0]   data_q;
    logic [1:0]    resp_q;

    logic [31:0]   off;
    logic          err_c;
    logic [IW-1:0] idx_c;
    logic          ar_fire;
    logic          r_fire;
    logic          resp_load;
    logic [IW-1:0] rd_idx;
    logic          rd_err;

    // Addresses below the base wrap to a huge offset and fall outside SPAN.
    assign off   = io.ar_bits_addr - BASE_ADDR;
    assign err_c = (io.ar_bits_addr[1:0] != 2'b00) | ({1'b0, off} >= SPAN);
    assign idx_c = off[IW+1:2];

    assign io.ar_ready    = (state == S_IDLE);
    assign io.r_valid     = (state == S_RESP);
    assign io.r_bits_data = data_q;
    assign io.r_bits_resp = resp_q;

    assign ar_fire   = io.ar_valid & io.ar_ready;
    assign r_fire    = io.r_ready & io.r_valid;
    // With zero latency the response is captured in the AR handshake cycle itself.
    assign resp_load = ((state == S_WAIT) && (cnt == 4'd0)) || (ar_fire && (LATENCY == 0));
    assign rd_idx    = (state == S_IDLE) ? idx_c : idx_q;
    assign rd_err    = (state == S_IDLE) ? err_c : err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            data_q <= 32'd0;
            resp_q <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (ar_fire) begin
                    idx_q <= idx_c;
                    err_q <= err_c;
                    cnt   <= CNT_INIT;
                    state <= (LATENCY == 0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: if (r_fire) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Read-before-write: a same-cycle preload is seen only by later reads.
            if (resp_load) begin
                data_q <= rd_err ? 32'd0 : mem[rd_idx];
                resp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (io_ld_en) mem[io_ld_idx] <= io_ld_data;
    end
endmodule
